// File: rtl/jt1943_sndcmd_pkg.sv
// Shared types and helpers for the main-CPU sound command transmitter.
package jt1943_sndcmd_pkg;

  // Width of the sound latch data path.
  localparam int unsigned DataW = 8;

  // Command pacing FSM states.
  typedef enum logic [0:0] {
    StIdle,
    StHold
  } state_e;

  // Bits needed to count 0..n-1; at least one bit so degenerate counts stay legal.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/jt1943_sndcmd_fifo.sv
// Synchronous DEPTH x 8 command FIFO. Pointers carry one extra wrap bit so
// full and empty are told apart without a separate counter.
module jt1943_sndcmd_fifo
  import jt1943_sndcmd_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     cen,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DataW-1:0]         din,
  output logic [DataW-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DataW-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q;
  logic [AW:0]      rd_q;
  logic             push_ok;
  logic             pop_ok;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign level = wr_q - rd_q;
  assign dout  = mem_q[rd_q[AW-1:0]];

  // A push into a full FIFO is still taken when the head leaves on the same cycle.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  // Pointer update; flush discards all queued bytes at once.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (cen) begin
      if (flush) begin
        wr_q <= '0;
        rd_q <= '0;
      end else begin
        if (push_ok) wr_q <= wr_q + (AW+1)'(1);
        if (pop_ok)  rd_q <= rd_q + (AW+1)'(1);
      end
    end
  end

  // Storage write; contents need no reset since the pointers gate every read.
  always_ff @(posedge clk) begin
    if (cen && push_ok && !flush) begin
      mem_q[wr_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/jt1943_sndcmd.sv
// Main-CPU sound command transmitter: queues CPU bytes, presents them one at
// a time on the sound latch, paced by a free-running sound interrupt.
module jt1943_sndcmd
  import jt1943_sndcmd_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned INT_PERIOD = 25000,
  parameter int unsigned INT_W      = 16,
  parameter int unsigned HOLD_INTS  = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   cen,
  input  logic [7:0]             cpu_dout,
  input  logic                   cmd_we,
  input  logic                   sres_we,
  output logic                   cmd_full,
  output logic [$clog2(DEPTH):0] cmd_level,
  output logic                   cmd_ovf,
  output logic [7:0]             main_dout,
  output logic                   main_latch_cs,
  output logic                   snd_int,
  output logic                   sres_b
);

  localparam int unsigned CW = cnt_width(INT_PERIOD);
  localparam int unsigned HW = cnt_width(HOLD_INTS);
  localparam logic [CW-1:0] CntLast  = CW'(INT_PERIOD - 1);
  localparam logic [CW-1:0] CntEdge  = CW'(INT_PERIOD - INT_W);
  localparam logic [HW-1:0] HoldLast = HW'(HOLD_INTS - 1);

  // Interrupt generator
  logic [CW-1:0] cnt_q, cnt_d;
  logic          snd_int_q;
  logic          int_edge;

  // Sound reset
  logic sres_b_q, sres_b_d;
  logic flush;

  // FSM and latch
  state_e        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          pop;
  logic          push;
  logic          ovf_q, ovf_d;
  logic [7:0]    dout_q, dout_d;
  logic          latch_q;

  // FIFO view
  logic [7:0] fifo_dout;
  logic       fifo_full;
  logic       fifo_empty;

  jt1943_sndcmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .cen     (cen),
    .flush   (flush),
    .push    (push),
    .pop     (pop),
    .din     (cpu_dout),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (cmd_level)
  );

  // Interrupt counter next value and the cycle that opens each interrupt window.
  always_comb begin
    cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + CW'(1);
  end

  assign int_edge = (cnt_q == CntEdge);

  // Free-running interrupt counter; snd_int tracks the counter it is registered with.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      snd_int_q <= 1'b0;
    end else if (cen) begin
      cnt_q     <= cnt_d;
      snd_int_q <= (cnt_d >= CntEdge);
    end
  end

  // Flush follows the value sres_b is about to take, so it lands with the falling edge.
  assign sres_b_d = sres_we ? ~cpu_dout[0] : sres_b_q;
  assign flush    = ~sres_b_d;

  // Sound reset level register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sres_b_q <= 1'b1;
    end else if (cen) begin
      sres_b_q <= sres_b_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
      hold_q  <= '0;
    end else if (cen) begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // FSM next state: pop in idle, then wait out HOLD_INTS interrupt edges.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    if (flush) begin
      state_d = StIdle;
      hold_d  = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            state_d = StHold;
            hold_d  = '0;
          end
        end
        StHold: begin
          if (int_edge) begin
            if (hold_q == HoldLast) begin
              state_d = StIdle;
              hold_d  = '0;
            end else begin
              hold_d = hold_q + HW'(1);
            end
          end
        end
      endcase
    end
  end

  // FSM outputs: pop/push strobes, overflow flag and latch data next values.
  always_comb begin
    pop    = (state_q == StIdle) && !fifo_empty && !flush;
    push   = cmd_we & ~flush;
    ovf_d  = ovf_q | (push & fifo_full & ~pop);
    dout_d = dout_q;
    if (flush) begin
      ovf_d  = 1'b0;
      dout_d = '0;
    end else if (pop) begin
      dout_d = fifo_dout;
    end
  end

  // Registered latch interface and sticky overflow.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ovf_q   <= 1'b0;
      dout_q  <= '0;
      latch_q <= 1'b0;
    end else if (cen) begin
      ovf_q   <= ovf_d;
      dout_q  <= dout_d;
      latch_q <= pop;
    end
  end

  assign cmd_full      = fifo_full;
  assign cmd_ovf       = ovf_q;
  assign main_dout     = dout_q;
  assign main_latch_cs = latch_q;
  assign snd_int       = snd_int_q;
  assign sres_b        = sres_b_q;

endmodule
